// File: rtl/ex_mem_stage.sv
// Execute->memory pipeline stage: resolves branches/jumps into a one-cycle redirect pulse
// and carries each instruction's result and control through a 2-entry skid buffer.
module ex_mem_stage #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [XLEN-1:0]      i_alu_result,
    input  logic                 i_zero,
    input  logic                 i_neg,
    input  logic                 i_negU,
    input  logic [XLEN-1:0]      i_pc,
    input  logic [XLEN-1:0]      i_imm,
    input  logic [XLEN-1:0]      i_rs2_data,
    input  logic [RF_ADDR_W-1:0] i_rd,
    input  logic [2:0]           i_funct3,
    input  logic                 i_branch,
    input  logic                 i_jal,
    input  logic                 i_jalr,
    input  logic                 i_reg_write,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [XLEN-1:0]      o_wb_data,
    output logic [XLEN-1:0]      o_addr,
    output logic [XLEN-1:0]      o_rs2_data,
    output logic [RF_ADDR_W-1:0] o_rd,
    output logic [2:0]           o_funct3,
    output logic                 o_reg_write,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_redirect,
    output logic [XLEN-1:0]      o_redirect_pc,
    output logic                 o_misalign
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [XLEN-1:0]      wb_data;
        logic [XLEN-1:0]      addr;
        logic [XLEN-1:0]      rs2_data;
        logic [RF_ADDR_W-1:0] rd;
        logic [2:0]           funct3;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
    } entry_t;

    buf_state_t      state, next_state;
    logic            ready_q;
    entry_t          main_q, skid_q, in_entry;
    logic            accept, pop;
    logic            load_main_in, load_skid_in, load_main_skid;
    logic            cond, taken;
    logic [XLEN-1:0] target;
    logic            redirect_q, misalign_q;
    logic [XLEN-1:0] redirect_pc_q;

    assign accept  = i_valid & ready_q & ~i_flush;
    assign o_valid = (state != EMPTY);
    assign o_ready = ready_q;
    assign pop     = o_valid & i_ready;

    // Writeback data is resolved at the input so both buffer slots stay a plain copy
    always_comb begin
        in_entry           = '0;
        in_entry.wb_data   = (i_jal | i_jalr) ? (i_pc + XLEN'(4)) : i_alu_result;
        in_entry.addr      = i_alu_result;
        in_entry.rs2_data  = i_rs2_data;
        in_entry.rd        = i_rd;
        in_entry.funct3    = i_funct3;
        in_entry.reg_write = i_reg_write;
        in_entry.mem_read  = i_mem_read;
        in_entry.mem_write = i_mem_write;
    end

    always_comb begin
        cond = 1'b0;
        case (i_funct3)
            3'b000:  cond = i_zero;
            3'b001:  cond = ~i_zero;
            3'b100:  cond = i_neg;
            3'b101:  cond = ~i_neg;
            3'b110:  cond = i_negU;
            3'b111:  cond = ~i_negU;
            default: cond = 1'b0;
        endcase
    end

    assign taken  = i_jal | i_jalr | (i_branch & cond);
    assign target = i_jalr ? {i_alu_result[XLEN-1:1], 1'b0} : (i_pc + i_imm);

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        if (i_flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        next_state   = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid_in = 1'b1;
                        next_state   = TWO;
                    end else if (pop) begin
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        next_state     = ONE;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != TWO);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_entry;
            end
        end
    end

    // Flush already blocks accept, so it also suppresses the redirect pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_q    <= 1'b0;
            misalign_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= accept & taken;
            misalign_q <= accept & taken & target[1];
            if (accept && taken) begin
                redirect_pc_q <= target;
            end
        end
    end

    assign o_wb_data     = main_q.wb_data;
    assign o_addr        = main_q.addr;
    assign o_rs2_data    = main_q.rs2_data;
    assign o_rd          = main_q.rd;
    assign o_funct3      = main_q.funct3;
    assign o_reg_write   = main_q.reg_write;
    assign o_mem_read    = main_q.mem_read;
    assign o_mem_write   = main_q.mem_write;
    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
    assign o_misalign    = misalign_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: branch resolution, skid buffering,
// flush and asynchronous reset.
module tb_ex_mem_stage;

    localparam int XLEN      = 32;
    localparam int RF_ADDR_W = 5;

    logic                 i_clk;
    logic                 i_rst_n;
    logic                 i_valid;
    logic                 o_ready;
    logic [XLEN-1:0]      i_alu_result;
    logic                 i_zero;
    logic                 i_neg;
    logic                 i_negU;
    logic [XLEN-1:0]      i_pc;
    logic [XLEN-1:0]      i_imm;
    logic [XLEN-1:0]      i_rs2_data;
    logic [RF_ADDR_W-1:0] i_rd;
    logic [2:0]           i_funct3;
    logic                 i_branch;
    logic                 i_jal;
    logic                 i_jalr;
    logic                 i_reg_write;
    logic                 i_mem_read;
    logic                 i_mem_write;
    logic                 i_flush;
    logic                 o_valid;
    logic                 i_ready;
    logic [XLEN-1:0]      o_wb_data;
    logic [XLEN-1:0]      o_addr;
    logic [XLEN-1:0]      o_rs2_data;
    logic [RF_ADDR_W-1:0] o_rd;
    logic [2:0]           o_funct3;
    logic                 o_reg_write;
    logic                 o_mem_read;
    logic                 o_mem_write;
    logic                 o_redirect;
    logic [XLEN-1:0]      o_redirect_pc;
    logic                 o_misalign;

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.XLEN(XLEN), .RF_ADDR_W(RF_ADDR_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_result(i_alu_result), .i_zero(i_zero), .i_neg(i_neg), .i_negU(i_negU),
        .i_pc(i_pc), .i_imm(i_imm), .i_rs2_data(i_rs2_data), .i_rd(i_rd),
        .i_funct3(i_funct3), .i_branch(i_branch), .i_jal(i_jal), .i_jalr(i_jalr),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_wb_data(o_wb_data),
        .o_addr(o_addr), .o_rs2_data(o_rs2_data), .o_rd(o_rd), .o_funct3(o_funct3),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_misalign(o_misalign)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_valid = 0; i_alu_result = '0; i_zero = 0; i_neg = 0; i_negU = 0;
        i_pc = '0; i_imm = '0; i_rs2_data = '0; i_rd = '0; i_funct3 = 3'b010;
        i_branch = 0; i_jal = 0; i_jalr = 0; i_reg_write = 0; i_mem_read = 0;
        i_mem_write = 0; i_flush = 0;
    endtask

    task automatic drain();
        clear_inputs();
        i_ready = 1;
        step();
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        i_ready = 1;
        i_rst_n = 0;
        #12;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_hs valid=%b ready=%b expected 0/1", o_valid, o_ready);
        end
        checks++;
        if (o_redirect !== 1'b0 || o_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_redirect redirect=%b misalign=%b expected 0/0", o_redirect, o_misalign);
        end
        checks++;
        if (o_wb_data !== '0 || o_addr !== '0 || o_redirect_pc !== '0 || o_rd !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data wb=%h addr=%h rpc=%h rd=%h expected 0", o_wb_data, o_addr, o_redirect_pc, o_rd);
        end
        @(negedge i_clk);
        i_rst_n = 1;
        step();
    endtask

    task automatic test_beq();
        clear_inputs();
        i_valid = 1; i_pc = 32'h100; i_imm = 32'h20; i_zero = 1; i_branch = 1;
        i_funct3 = 3'b000; i_rd = 5'd7; i_rs2_data = 32'hCAFE;
        step();
        i_valid = 0;
        checks++;
        if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h120 || o_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL beq_redirect got %b/%h/%b expected 1/00000120/0", o_redirect, o_redirect_pc, o_misalign);
        end
        checks++;
        if (o_valid !== 1'b1 || o_rd !== 5'd7 || o_rs2_data !== 32'hCAFE || o_funct3 !== 3'b000) begin
            errors++;
            $display("[TB] FAIL beq_payload valid=%b rd=%0d rs2=%h f3=%b expected 1/7/cafe/000", o_valid, o_rd, o_rs2_data, o_funct3);
        end
        step();
        checks++;
        if (o_redirect !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL beq_pulse_end redirect=%b valid=%b expected 0/0", o_redirect, o_valid);
        end
    endtask

    task automatic test_bltu();
        clear_inputs();
        i_valid = 1; i_pc = 32'h300; i_imm = 32'h40; i_funct3 = 3'b110; i_branch = 1;
        i_negU = 0; i_neg = 1;
        step();
        i_valid = 0;
        checks++;
        if (o_redirect !== 1'b0 || o_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bltu_not_taken redirect=%b valid=%b expected 0/1", o_redirect, o_valid);
        end
        drain();
        clear_inputs();
        i_valid = 1; i_pc = 32'h200; i_imm = 32'hFFFF_FFF0; i_funct3 = 3'b110; i_branch = 1;
        i_negU = 1;
        step();
        i_valid = 0;
        checks++;
        if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h1F0 || o_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bltu_taken got %b/%h/%b expected 1/000001f0/0", o_redirect, o_redirect_pc, o_misalign);
        end
        drain();
    endtask

    task automatic test_jumps();
        clear_inputs();
        i_valid = 1; i_jalr = 1; i_alu_result = 32'h2003; i_pc = 32'h40; i_reg_write = 1;
        i_rd = 5'd1;
        step();
        i_valid = 0;
        checks++;
        if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h2002 || o_misalign !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jalr_redirect got %b/%h/%b expected 1/00002002/1", o_redirect, o_redirect_pc, o_misalign);
        end
        checks++;
        if (o_wb_data !== 32'h44 || o_addr !== 32'h2003 || o_reg_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jalr_wb wb=%h addr=%h rw=%b expected 00000044/00002003/1", o_wb_data, o_addr, o_reg_write);
        end
        drain();
        clear_inputs();
        i_valid = 1; i_jal = 1; i_pc = 32'hFFFF_FFFC; i_imm = 32'h8; i_alu_result = 32'h55;
        step();
        i_valid = 0;
        checks++;
        if (o_redirect_pc !== 32'h4 || o_wb_data !== 32'h0 || o_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jal_wrap rpc=%h wb=%h mis=%b expected 00000004/00000000/0", o_redirect_pc, o_wb_data, o_misalign);
        end
        drain();
        clear_inputs();
        i_valid = 1; i_alu_result = 32'h1234; i_mem_read = 1; i_pc = 32'h80; i_funct3 = 3'b010;
        step();
        i_valid = 0;
        checks++;
        if (o_wb_data !== 32'h1234 || o_mem_read !== 1'b1 || o_redirect !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_wb wb=%h mr=%b redirect=%b expected 00001234/1/0", o_wb_data, o_mem_read, o_redirect);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] got [4];
        int count;
        logic fire;
        clear_inputs();
        i_ready = 0;
        i_valid = 1; i_alu_result = 32'hA; i_mem_write = 1;
        step();
        i_alu_result = 32'hB;
        step();
        checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_addr !== 32'hA) begin
            errors++;
            $display("[TB] FAIL bp_full ready=%b valid=%b addr=%h expected 0/1/0000000a", o_ready, o_valid, o_addr);
        end
        i_alu_result = 32'hC;
        step();
        checks++;
        if (o_ready !== 1'b0 || o_addr !== 32'hA) begin
            errors++;
            $display("[TB] FAIL bp_hold ready=%b addr=%h expected 0/0000000a", o_ready, o_addr);
        end
        i_ready = 1;
        count = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (o_valid) begin
                if (count < 4) got[count] = o_addr;
                count++;
            end
            fire = i_valid & o_ready;
            step();
            if (fire) i_valid = 0;
        end
        checks++;
        if (count !== 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
            errors++;
            $display("[TB] FAIL bp_order count=%0d got %h %h %h expected 3 a b c", count, got[0], got[1], got[2]);
        end
        drain();
    endtask

    task automatic test_flush();
        clear_inputs();
        i_ready = 0;
        i_valid = 1; i_alu_result = 32'h11;
        step();
        i_alu_result = 32'h22;
        step();
        i_pc = 32'h100; i_imm = 32'h20; i_zero = 1; i_branch = 1; i_funct3 = 3'b000;
        i_flush = 1;
        step();
        i_flush = 0;
        i_valid = 0;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_redirect !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush valid=%b ready=%b redirect=%b expected 0/1/0", o_valid, o_ready, o_redirect);
        end
        drain();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        i_ready = 0;
        i_valid = 1; i_alu_result = 32'h33;
        step();
        i_jal = 1; i_pc = 32'h500; i_imm = 32'h10;
        step();
        i_valid = 0;
        checks++;
        if (o_redirect !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset redirect=%b ready=%b expected 1/0", o_redirect, o_ready);
        end
        #1;
        i_rst_n = 0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_redirect !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset valid=%b ready=%b redirect=%b expected 0/1/0", o_valid, o_ready, o_redirect);
        end
        @(negedge i_clk);
        i_rst_n = 1;
        drain();
    endtask

    initial begin
        i_rst_n = 1;
        clear_inputs();
        i_ready = 1;
        test_reset();
        test_beq();
        test_bltu();
        test_jumps();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
